// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - fetch/decode pipeline register with a small skid buffer
// Holds decode outputs on stall, injects NOP bubbles, buffers fetch responses during stalls.
module if_id_stage #(
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_valid,
    input  logic [31:0] instruction_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pre_pc_in,
    input  logic        stall,
    input  logic        flush,
    output logic        fetch_ready,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic [31:0] pre_pc_out,
    output logic        valid_out
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [95:0]   buf_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   pre_pc_q, pre_pc_d;
    logic          valid_q, valid_d;
    logic          accept;
    logic          push;
    logic [95:0]   head;

    assign fetch_ready = rst && (count_q < CW'(DEPTH));
    assign accept      = imem_valid && fetch_ready;
    assign head        = buf_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        pre_pc_d = pre_pc_q;
        valid_d  = valid_q;
        push     = 1'b0;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            instr_d  = NOP;
            pc_d     = '0;
            pre_pc_d = '0;
            valid_d  = 1'b0;
        end else if (stall) begin
            if (accept) begin
                push     = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                count_d  = count_q + CW'(1);
            end
        end else if (count_q != '0) begin
            // Drain the buffer first so instruction order is preserved.
            {instr_d, pc_d, pre_pc_d} = head;
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (accept) begin
                push     = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                count_d = count_q - CW'(1);
            end
        end else if (accept) begin
            instr_d  = instruction_in;
            pc_d     = pc_in;
            pre_pc_d = pre_pc_in;
            valid_d  = 1'b1;
        end else begin
            instr_d = NOP;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            instr_q  <= NOP;
            pc_q     <= '0;
            pre_pc_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            pre_pc_q <= pre_pc_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            buf_q[wr_ptr_q] <= {instruction_in, pc_in, pre_pc_in};
        end
    end

    assign instruction_out = instr_q;
    assign pc_out          = pc_q;
    assign pre_pc_out      = pre_pc_q;
    assign valid_out       = valid_q;
endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed self-checking bench for if_id_stage
module tb_if_id_stage;
    logic        clk;
    logic        rst;
    logic        imem_valid;
    logic [31:0] instruction_in;
    logic [31:0] pc_in;
    logic [31:0] pre_pc_in;
    logic        stall;
    logic        flush;
    logic        fetch_ready;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic [31:0] pre_pc_out;
    logic        valid_out;

    int checks;
    int errors;

    if_id_stage #(.DEPTH(2), .NOP(32'h00000013)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_valid     (imem_valid),
        .instruction_in (instruction_in),
        .pc_in          (pc_in),
        .pre_pc_in      (pre_pc_in),
        .stall          (stall),
        .flush          (flush),
        .fetch_ready    (fetch_ready),
        .instruction_out(instruction_out),
        .pc_out         (pc_out),
        .pre_pc_out     (pre_pc_out),
        .valid_out      (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pre);
        imem_valid     = v;
        instruction_in = ins;
        pc_in          = pc;
        pre_pc_in      = pre;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, valid_out}, {31'd0, v});
        chk({tag, "_instr"}, instruction_out, ins);
        chk({tag, "_pc"}, pc_out, pc);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0, 32'h0);

        // Reset held for two edges
        step();
        chk_out("rst1", 1'b0, 32'h13, 32'h0);
        chk("rst1_ready", {31'd0, fetch_ready}, 32'd0);
        step();
        chk_out("rst2", 1'b0, 32'h13, 32'h0);
        chk("rst2_ready", {31'd0, fetch_ready}, 32'd0);
        chk("rst2_prepc", pre_pc_out, 32'h0);

        // Stream two instructions, one-cycle latency each
        rst = 1'b1;
        offer(1'b1, 32'h00500093, 32'h0, 32'h0);
        #1;
        chk("ready_after_rst", {31'd0, fetch_ready}, 32'd1);
        step();
        chk_out("stream0", 1'b1, 32'h00500093, 32'h0);
        offer(1'b1, 32'h00A00113, 32'h4, 32'h0);
        step();
        chk_out("stream1", 1'b1, 32'h00A00113, 32'h4);
        chk("stream1_prepc", pre_pc_out, 32'h0);

        // Stall three cycles offering A, B, C; C must be ignored
        stall = 1'b1;
        offer(1'b1, 32'h11111111, 32'h8, 32'h4);
        step();
        chk_out("stallA", 1'b1, 32'h00A00113, 32'h4);
        chk("stallA_ready", {31'd0, fetch_ready}, 32'd1);
        offer(1'b1, 32'h22222222, 32'hC, 32'h8);
        step();
        chk_out("stallB", 1'b1, 32'h00A00113, 32'h4);
        chk("stallB_ready", {31'd0, fetch_ready}, 32'd0);
        chk("stallB_count", 32'(dut.count_q), 32'd2);
        offer(1'b1, 32'h33333333, 32'h10, 32'hC);
        step();
        chk_out("stallC", 1'b1, 32'h00A00113, 32'h4);
        chk("stallC_count", 32'(dut.count_q), 32'd2);

        // Release: A then B drain, then a bubble with pc held
        stall = 1'b0;
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        chk_out("drainA", 1'b1, 32'h11111111, 32'h8);
        chk("drainA_prepc", pre_pc_out, 32'h4);
        chk("drainA_ready", {31'd0, fetch_ready}, 32'd1);
        step();
        chk_out("drainB", 1'b1, 32'h22222222, 32'hC);
        step();
        chk_out("bubble1", 1'b0, 32'h13, 32'hC);
        step();
        chk_out("bubble2", 1'b0, 32'h13, 32'hC);

        // Pop and push in the same cycle keeps count at one
        stall = 1'b1;
        offer(1'b1, 32'h44444444, 32'h20, 32'h1C);
        step();
        chk("pp_fill_count", 32'(dut.count_q), 32'd1);
        chk_out("pp_hold", 1'b0, 32'h13, 32'hC);
        stall = 1'b0;
        offer(1'b1, 32'h55555555, 32'h24, 32'h20);
        step();
        chk_out("pp_outA", 1'b1, 32'h44444444, 32'h20);
        chk("pp_count", 32'(dut.count_q), 32'd1);
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        chk_out("pp_outB", 1'b1, 32'h55555555, 32'h24);
        chk("pp_prepc", pre_pc_out, 32'h20);

        // Flush with stall and a valid offer while the buffer is full
        stall = 1'b1;
        offer(1'b1, 32'h66666666, 32'h30, 32'h2C);
        step();
        offer(1'b1, 32'h77777777, 32'h34, 32'h30);
        step();
        chk("fl_full_count", 32'(dut.count_q), 32'd2);
        flush = 1'b1;
        offer(1'b1, 32'h88888888, 32'h38, 32'h34);
        step();
        chk_out("flush", 1'b0, 32'h13, 32'h0);
        chk("flush_prepc", pre_pc_out, 32'h0);
        chk("flush_count", 32'(dut.count_q), 32'd0);
        chk("flush_ready", {31'd0, fetch_ready}, 32'd1);
        flush = 1'b0;
        stall = 1'b0;
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        chk_out("post_flush", 1'b0, 32'h13, 32'h0);

        // Flush while a pushed entry is accepted in the same cycle
        stall = 1'b1;
        offer(1'b1, 32'h99999999, 32'h40, 32'h3C);
        flush = 1'b1;
        step();
        chk("fl_acc_count", 32'(dut.count_q), 32'd0);
        flush = 1'b0;
        stall = 1'b0;
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        chk_out("fl_acc_drop", 1'b0, 32'h13, 32'h0);

        // Reset in the middle of a stall with two buffered entries
        stall = 1'b1;
        offer(1'b1, 32'hAAAAAAAA, 32'h50, 32'h4C);
        step();
        offer(1'b1, 32'hBBBBBBBB, 32'h54, 32'h50);
        step();
        chk("mr_count", 32'(dut.count_q), 32'd2);
        rst = 1'b0;
        offer(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        chk_out("mid_rst", 1'b0, 32'h13, 32'h0);
        chk("mid_rst_count", 32'(dut.count_q), 32'd0);
        chk("mid_rst_ready", {31'd0, fetch_ready}, 32'd0);
        rst = 1'b1;
        stall = 1'b0;
        step();
        chk_out("after_rst1", 1'b0, 32'h13, 32'h0);
        step();
        chk_out("after_rst2", 1'b0, 32'h13, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
